// File: rtl/mvau_weight_fetch.sv
// mvau_weight_fetch: weight-memory sweep sequencer with a 2-entry output FIFO.
// Optional `MVAU_WFETCH_PASS_CNT_EN adds a saturating pass_cnt output.
module mvau_weight_fetch #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [REP_BW-1:0]       num_reps,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_out,
    output logic [SIMD*TW-1:0]      out_wgt,
    output logic                    out_v,
    input  logic                    out_rdy,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
`ifdef MVAU_WFETCH_PASS_CNT_EN
    ,
    output logic [REP_BW-1:0]       pass_cnt
`endif
);

    localparam int W = SIMD * TW;
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST =
        WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [REP_BW-1:0] rep;
    logic [REP_BW-1:0] reps_m1;
    logic              pend;
    logic              pend_last;

    logic [W-1:0]      fifo_d [2];
    logic              fifo_l [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        fifo_cnt;

    logic              pop;
    logic              push;
    logic              issue;
    logic              accept;
    logic              addr_end;
    logic              rep_end;
    logic [2:0]        occ;

    assign out_v    = (fifo_cnt != 2'd0);
    assign out_wgt  = fifo_d[rd_ptr];
    assign out_last = out_v && fifo_l[rd_ptr];
    assign pop      = out_v && out_rdy;
    assign push     = pend;
    assign addr_end = (wmem_addr == ADDR_LAST);
    assign rep_end  = (rep == reps_m1);
    assign accept   = (state == IDLE) && start && (num_reps != '0);

    // Words held plus the one in flight must leave room after this cycle's pop.
    assign occ   = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};
    assign issue = (state == RUN) && (occ < 3'd2);

    always_ff @(posedge aclk) begin
        if (rst) begin
            state     <= IDLE;
            wmem_addr <= '0;
            rep       <= '0;
            reps_m1   <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= issue;
            if (issue)
                pend_last <= addr_end;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_reps != '0) begin
                            state     <= RUN;
                            reps_m1   <= num_reps - REP_BW'(1);
                            wmem_addr <= '0;
                            rep       <= '0;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (addr_end) begin
                            wmem_addr <= '0;
                            if (rep_end)
                                state <= DRAIN;
                            else
                                rep <= rep + REP_BW'(1);
                        end else begin
                            wmem_addr <= wmem_addr + WMEM_ADDR_BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_cnt == 2'd0 && !pend) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            fifo_cnt  <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            fifo_d[0] <= '0;
            fifo_d[1] <= '0;
            fifo_l[0] <= 1'b0;
            fifo_l[1] <= 1'b0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr] <= wmem_out;
                fifo_l[wr_ptr] <= pend_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef MVAU_WFETCH_PASS_CNT_EN
    always_ff @(posedge aclk) begin
        if (rst)
            pass_cnt <= '0;
        else if (accept)
            pass_cnt <= '0;
        else if (pop && out_last && pass_cnt != '1)
            pass_cnt <= pass_cnt + REP_BW'(1);
    end
`endif

endmodule

// File: tb/tb_mvau_weight_fetch.sv
// tb_mvau_weight_fetch: vector table for the basic job plus randomized
// jobs scored against an expected word stream derived from num_reps.
`timescale 1ns/1ps
module tb_mvau_weight_fetch;

    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int ABW   = 4;
    localparam int RBW   = 16;

    logic           aclk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           out_rdy = 1'b0;
    logic [RBW-1:0] num_reps = '0;
    logic [ABW-1:0] wmem_addr;
    logic [W-1:0]   wmem_out = '0;
    logic [W-1:0]   out_wgt;
    logic           out_v;
    logic           out_last;
    logic           busy;
    logic           done;
`ifdef MVAU_WFETCH_PASS_CNT_EN
    logic [RBW-1:0] pass_cnt;
`endif

    logic [W-1:0] mem [DEPTH];
    int checks = 0;
    int failures = 0;

    mvau_weight_fetch #(
        .SIMD(2), .TW(1), .WMEM_DEPTH(DEPTH),
        .WMEM_ADDR_BW(ABW), .REP_BW(RBW)
    ) dut (
        .aclk(aclk),
        .rst(rst),
        .start(start),
        .num_reps(num_reps),
        .wmem_addr(wmem_addr),
        .wmem_out(wmem_out),
        .out_wgt(out_wgt),
        .out_v(out_v),
        .out_rdy(out_rdy),
        .out_last(out_last),
        .busy(busy),
        .done(done)
`ifdef MVAU_WFETCH_PASS_CNT_EN
        ,
        .pass_cnt(pass_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = W'(i);
    end

    // Weight memory with a registered read port.
    always @(posedge aclk)
        wmem_out <= mem[wmem_addr[1:0]];

    typedef struct {
        logic           rst;
        logic           start;
        logic [RBW-1:0] reps;
        logic           rdy;
        logic           v;
        logic [W-1:0]   w;
        logic           last;
        logic           busy;
        logic           done;
        logic [ABW-1:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s,
                                input int n, input logic rd,
                                input logic v, input int w,
                                input logic l, input logic b,
                                input logic d, input int a);
        vec_t t;
        t.rst = r; t.start = s; t.reps = RBW'(n); t.rdy = rd;
        t.v = v; t.w = W'(w); t.last = l; t.busy = b;
        t.done = d; t.addr = ABW'(a);
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // mode 0: always ready, 1: ready every third cycle, 2: random ready.
    task automatic run_job(input int reps, input int mode, input int inj,
                           input string tag);
        int total;
        int budget;
        int idx, first_v, done_at, last_at, ndone;
        int stall_bad, busy_bad, credit_bad, post_v, issues, lasts, pc_bad;
        logic [W-1:0]   pw;
        logic           pl;
        bit             pstall;
        logic [ABW-1:0] paddr;
        total = reps * DEPTH;
        budget = total * 8 + 40;
        idx = 0; first_v = -1; done_at = -1; last_at = -1; ndone = 0;
        stall_bad = 0; busy_bad = 0; credit_bad = 0; post_v = 0;
        issues = 0; lasts = 0; pc_bad = 0;
        pw = '0; pl = 1'b0; pstall = 1'b0;
        num_reps = RBW'(reps);
        start = 1'b1;
        step();
        paddr = wmem_addr;
        chk({tag, ".addr0"}, 32'(wmem_addr), 32'd0);
        for (int c = 0; c < budget; c++) begin
            if (c == inj) begin
                start = 1'b1;
                num_reps = RBW'(5);
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = (c % 3 == 0);
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
            if (wmem_addr != paddr)
                issues++;
            paddr = wmem_addr;
            if (issues - idx > 2)
                credit_bad++;
            if (out_v && first_v < 0)
                first_v = c;
            if (pstall && (!out_v || out_wgt !== pw || out_last !== pl))
                stall_bad++;
            if (done) begin
                ndone++;
                if (done_at < 0)
                    done_at = c;
            end
            if (busy !== (done_at < 0))
                busy_bad++;
            if (done_at >= 0 && out_v)
                post_v++;
`ifdef MVAU_WFETCH_PASS_CNT_EN
            if (pass_cnt !== RBW'(lasts))
                pc_bad++;
`endif
            if (out_v && out_rdy) begin
                if (idx < total) begin
                    chk($sformatf("%s.w%0d", tag, idx),
                        32'(out_wgt), 32'(idx % DEPTH));
                    chk($sformatf("%s.last%0d", tag, idx),
                        32'(out_last), 32'(idx % DEPTH == DEPTH - 1));
                    if (idx % DEPTH == DEPTH - 1)
                        lasts++;
                end
                idx++;
                if (idx == total)
                    last_at = c;
            end
            pstall = out_v && !out_rdy;
            pw = out_wgt;
            pl = out_last;
            if (done_at >= 0 && c >= done_at + 3)
                break;
            step();
        end
        start = 1'b0;
        out_rdy = 1'b1;
        chk({tag, ".count"}, 32'(idx), 32'(total));
        chk({tag, ".first_v"}, 32'(first_v), 32'd2);
        chk({tag, ".done_at"}, 32'(done_at), 32'(last_at + 2));
        chk({tag, ".ndone"}, 32'(ndone), 32'd1);
        chk({tag, ".stall"}, 32'(stall_bad), 32'd0);
        chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
        chk({tag, ".credit"}, 32'(credit_bad), 32'd0);
        chk({tag, ".post_v"}, 32'(post_v), 32'd0);
`ifdef MVAU_WFETCH_PASS_CNT_EN
        chk({tag, ".pass_trk"}, 32'(pc_bad), 32'd0);
        chk({tag, ".pass_hold"}, 32'(pass_cnt), 32'(reps));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst start reps rdy | v w last busy done addr (after next edge)
        add(1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 1,  0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1,  1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 1,  1, 1, 0, 1, 0, 3);
        add(0, 0, 0, 1,  1, 2, 0, 1, 0, 0);
        add(0, 0, 0, 1,  1, 3, 1, 1, 0, 1);
        add(0, 0, 0, 1,  1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 1,  1, 1, 0, 1, 0, 3);
        add(0, 0, 0, 1,  1, 2, 0, 1, 0, 0);
        add(0, 0, 0, 1,  1, 3, 1, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            start = vecs[i].start;
            num_reps = vecs[i].reps;
            out_rdy = vecs[i].rdy;
            step();
            if (vecs[i].v)
                chk($sformatf("vec%0d.w", i), 32'(out_wgt), 32'(vecs[i].w));
            chk($sformatf("vec%0d.v", i), 32'(out_v), 32'(vecs[i].v));
            chk($sformatf("vec%0d.last", i), 32'(out_last), 32'(vecs[i].last));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d.addr", i), 32'(wmem_addr), 32'(vecs[i].addr));
        end
        start = 1'b0;

        run_job(3, 1, -1, "stall3");

        // Fill the FIFO with the consumer stalled, then reset mid-sweep.
        out_rdy = 1'b0;
        num_reps = RBW'(2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rstmid.full_v", 32'(out_v), 32'd1);
        chk("rstmid.head", 32'(out_wgt), 32'd0);
        chk("rstmid.addr_pre", 32'(wmem_addr), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.v", 32'(out_v), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.addr", 32'(wmem_addr), 32'd0);
        chk("rstmid.last", 32'(out_last), 32'd0);
        step();
        chk("rstmid.nodone", 32'(done), 32'd0);
        chk("rstmid.v2", 32'(out_v), 32'd0);
        out_rdy = 1'b1;
        run_job(1, 0, -1, "after_rst");

        run_job(2, 0, 4, "restart_ign");

        for (int k = 0; k < 4; k++)
            run_job(int'($urandom_range(1, 4)), 2, -1, $sformatf("rnd%0d", k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
